segre_ptw: RTL and testbench

//  Page-table walker: refills the TLB.
//  - On a TLB miss, reads the single-level PTE for the missing VPN from memory and writes the translation into the TLB.
//  - An invalid PTE is reported as a page fault instead.
//  - Sits between the TLB miss/new_entry ports and the data-memory arbiter.

---
 rtl/segre_ptw.sv | 158 +++++++++++++++
 tb/tb_segre_ptw.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/segre_ptw.sv
// ============================================================================
// Module   : segre_ptw
// Purpose  : Single-level page-table walker that refills the TLB on a miss.
//            Optional watchdog enabled by defining SEGRE_PTW_TIMEOUT_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module segre_ptw #(
    parameter int VPN_W          = 20,
    parameter int PPN_W          = 8,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             miss_i,
    input  logic [VPN_W-1:0] vaddr_i,
    input  logic [31:0]      ptbr_i,
    input  logic             flush_i,
    output logic             busy_o,
    output logic             mem_req_o,
    output logic [31:0]      mem_addr_o,
    input  logic             mem_gnt_i,
    input  logic             mem_rvalid_i,
    input  logic [31:0]      mem_rdata_i,
    output logic             tlb_new_entry_o,
    output logic [VPN_W-1:0] tlb_vaddr_o,
    output logic [PPN_W-1:0] tlb_paddr_o,
    output logic [1:0]       tlb_prot_o,
    output logic             fault_o,
    output logic [1:0]       fault_code_o,
    output logic [VPN_W-1:0] fault_vaddr_o
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        REQ   = 3'd1,
        WAIT  = 3'd2,
        DONE  = 3'd3,
        DRAIN = 3'd4
    } state_e;

    state_e             state, state_next;
    logic [VPN_W-1:0]   vpn_q;
    logic [31:0]        ptbr_q;
    logic               pte_v_q;
    logic [1:0]         pte_prot_q;
    logic [PPN_W-1:0]   pte_ppn_q;
    logic               req_q;
    logic               timeout_q;
    logic               expire;
    logic               timeout_fire;
    logic               walk_start;
    logic               pte_capture;

    always_comb begin
        state_next   = state;
        timeout_fire = 1'b0;
        case (state)
            IDLE: begin
                if (miss_i && !flush_i) state_next = REQ;
            end
            REQ: begin
                if (flush_i)        state_next = mem_gnt_i ? DRAIN : IDLE;
                else if (mem_gnt_i) state_next = WAIT;
                else if (expire) begin
                    state_next   = IDLE;
                    timeout_fire = 1'b1;
                end
            end
            WAIT: begin
                if (flush_i)           state_next = mem_rvalid_i ? IDLE : DRAIN;
                else if (mem_rvalid_i) state_next = DONE;
                else if (expire) begin
                    state_next   = IDLE;
                    timeout_fire = 1'b1;
                end
            end
            DONE:    state_next = IDLE;
            DRAIN: begin
                if (mem_rvalid_i) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign walk_start  = (state == IDLE) && miss_i && !flush_i;
    assign pte_capture = (state == WAIT) && mem_rvalid_i && !flush_i;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state      <= IDLE;
            req_q      <= 1'b0;
            vpn_q      <= '0;
            ptbr_q     <= '0;
            pte_v_q    <= 1'b0;
            pte_prot_q <= '0;
            pte_ppn_q  <= '0;
        end else begin
            state <= state_next;
            req_q <= (state_next == REQ);
            if (walk_start) begin
                vpn_q  <= vaddr_i;
                ptbr_q <= ptbr_i;
            end
            if (pte_capture) begin
                pte_v_q    <= mem_rdata_i[0];
                pte_prot_q <= mem_rdata_i[2:1];
                pte_ppn_q  <= mem_rdata_i[PPN_W+7:8];
            end
        end
    end

`ifdef SEGRE_PTW_TIMEOUT_EN
    localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
    logic [CNT_W-1:0] cnt_q;

    // Cycle k of a walk (first REQ cycle = 1) sees cnt_q = k-1.
    assign expire = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            timeout_q <= timeout_fire;
            if (walk_start)
                cnt_q <= '0;
            else if (state == REQ || state == WAIT)
                cnt_q <= cnt_q + 1'b1;
        end
    end
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT_CYCLES == 0) | timeout_fire;
    assign expire         = 1'b0;
    assign timeout_q      = 1'b0;
`endif

    logic done_state;
    logic pte_fault;
    assign done_state = (state == DONE);
    assign pte_fault  = done_state && !pte_v_q;

    assign busy_o          = (state != IDLE);
    assign mem_req_o       = req_q;
    assign mem_addr_o      = ptbr_q + 32'({vpn_q, 2'b00});
    assign tlb_new_entry_o = done_state && pte_v_q;
    assign tlb_vaddr_o     = tlb_new_entry_o ? vpn_q      : '0;
    assign tlb_paddr_o     = tlb_new_entry_o ? pte_ppn_q  : '0;
    assign tlb_prot_o      = tlb_new_entry_o ? pte_prot_q : '0;
    assign fault_o         = pte_fault || timeout_q;
    assign fault_code_o    = timeout_q ? 2'b10 : (pte_fault ? 2'b01 : 2'b00);
    assign fault_vaddr_o   = fault_o ? vpn_q : '0;

endmodule

`default_nettype wire

// File: tb/tb_segre_ptw.sv
// ============================================================================
// Module   : tb_segre_ptw
// Purpose  : Directed self-checking bench for segre_ptw.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_segre_ptw;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        miss = 1'b0;
    logic [19:0] vaddr = '0;
    logic [31:0] ptbr = '0;
    logic        flush = 1'b0;
    logic        busy;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_gnt = 1'b0;
    logic        mem_rvalid = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic        tlb_new_entry;
    logic [19:0] tlb_vaddr;
    logic [7:0]  tlb_paddr;
    logic [1:0]  tlb_prot;
    logic        fault;
    logic [1:0]  fault_code;
    logic [19:0] fault_vaddr;

    int tests  = 0;
    int failed = 0;

    segre_ptw #(
        .VPN_W(20),
        .PPN_W(8),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .clk_i(clk),
        .rst_i(rst),
        .miss_i(miss),
        .vaddr_i(vaddr),
        .ptbr_i(ptbr),
        .flush_i(flush),
        .busy_o(busy),
        .mem_req_o(mem_req),
        .mem_addr_o(mem_addr),
        .mem_gnt_i(mem_gnt),
        .mem_rvalid_i(mem_rvalid),
        .mem_rdata_i(mem_rdata),
        .tlb_new_entry_o(tlb_new_entry),
        .tlb_vaddr_o(tlb_vaddr),
        .tlb_paddr_o(tlb_paddr),
        .tlb_prot_o(tlb_prot),
        .fault_o(fault),
        .fault_code_o(fault_code),
        .fault_vaddr_o(fault_vaddr)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_idle_zero(input string tag);
        check({tag, "_busy"},  32'(busy), 32'h0);
        check({tag, "_req"},   32'(mem_req), 32'h0);
        check({tag, "_tlb"},   32'(tlb_new_entry), 32'h0);
        check({tag, "_fault"}, 32'(fault), 32'h0);
        check({tag, "_data"},  {4'h0, tlb_vaddr, tlb_paddr}, 32'h0);
        check({tag, "_fdata"}, {10'h0, fault_code, fault_vaddr}, 32'h0);
    endtask

    // Leaves the bench in cycle 1 of the walk (REQ state).
    task automatic start_walk(input logic [31:0] base, input logic [19:0] vpn);
        ptbr  = base;
        vaddr = vpn;
        miss  = 1'b1;
        step();
        miss  = 1'b0;
    endtask

    initial begin
        step();
        step();
        rst = 1'b0;
        check_idle_zero("reset");
        check("reset_addr", mem_addr, 32'h0);

        // flush beats a simultaneous miss
        ptbr = 32'h1000; vaddr = 20'h0000A; miss = 1'b1; flush = 1'b1;
        step();
        miss = 1'b0; flush = 1'b0;
        check("flush_idle_busy", 32'(busy), 32'h0);

        // reset while in WAIT, late rvalid must be ignored
        start_walk(32'h1000, 20'h0000A);
        mem_gnt = 1'b1;
        step();
        mem_gnt = 1'b0;
        check("rst_wait_busy_pre", 32'(busy), 32'h1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_idle_zero("rst_mid");
        check("rst_mid_addr", mem_addr, 32'h0);
        mem_rvalid = 1'b1; mem_rdata = 32'h00000A03;
        step();
        mem_rvalid = 1'b0;
        check("rst_late_tlb", 32'(tlb_new_entry), 32'h0);
        check("rst_late_busy", 32'(busy), 32'h0);

        // valid PTE, minimum latency
        start_walk(32'h1000, 20'h0000A);
        check("walk_req", 32'(mem_req), 32'h1);
        check("walk_addr", mem_addr, 32'h00001028);
        check("walk_busy", 32'(busy), 32'h1);
        mem_gnt = 1'b1;
        step();
        mem_gnt = 1'b0;
        check("walk_req_drop", 32'(mem_req), 32'h0);
        mem_rvalid = 1'b1; mem_rdata = 32'h00000A03;
        step();
        mem_rvalid = 1'b0;
        check("walk_tlb", 32'(tlb_new_entry), 32'h1);
        check("walk_vaddr", 32'(tlb_vaddr), 32'h0000A);
        check("walk_paddr", 32'(tlb_paddr), 32'h0A);
        check("walk_prot", 32'(tlb_prot), 32'h1);
        check("walk_nofault", 32'(fault), 32'h0);
        step();
        check_idle_zero("walk_after");

        // invalid PTE -> page fault
        start_walk(32'h1000, 20'h0000A);
        mem_gnt = 1'b1;
        step();
        mem_gnt = 1'b0;
        mem_rvalid = 1'b1; mem_rdata = 32'h00000A02;
        step();
        mem_rvalid = 1'b0;
        check("pf_fault", 32'(fault), 32'h1);
        check("pf_code", 32'(fault_code), 32'h1);
        check("pf_vaddr", 32'(fault_vaddr), 32'h0000A);
        check("pf_tlb", 32'(tlb_new_entry), 32'h0);
        check("pf_paddr", 32'(tlb_paddr), 32'h0);
        step();
        check_idle_zero("pf_after");

        // grant withheld for 5 cycles
        start_walk(32'h80000000, 20'h12345);
        for (int i = 0; i < 5; i++) begin
            check("stall_req", 32'(mem_req), 32'h1);
            check("stall_addr", mem_addr, 32'h80048D14);
            step();
        end
        check("stall_req_end", 32'(mem_req), 32'h1);
        mem_gnt = 1'b1;
        step();
        mem_gnt = 1'b0;
        mem_rvalid = 1'b1; mem_rdata = 32'h00005507;
        step();
        mem_rvalid = 1'b0;
        check("stall_tlb", 32'(tlb_new_entry), 32'h1);
        check("stall_vaddr", 32'(tlb_vaddr), 32'h12345);
        check("stall_paddr", 32'(tlb_paddr), 32'h55);
        check("stall_prot", 32'(tlb_prot), 32'h3);
        step();

        // flush in WAIT -> DRAIN, rvalid 3 cycles later
        start_walk(32'h1000, 20'h00001);
        mem_gnt = 1'b1;
        step();
        mem_gnt = 1'b0;
        flush = 1'b1;
        step();
        flush = 1'b0;
        check("drain_busy1", 32'(busy), 32'h1);
        step();
        check("drain_busy2", 32'(busy), 32'h1);
        mem_rvalid = 1'b1; mem_rdata = 32'h00000A03;
        miss = 1'b1; vaddr = 20'h00077;
        check("drain_busy3", 32'(busy), 32'h1);
        step();
        mem_rvalid = 1'b0; miss = 1'b0;
        check("drain_busy_fall", 32'(busy), 32'h0);
        check("drain_tlb", 32'(tlb_new_entry), 32'h0);
        check("drain_req", 32'(mem_req), 32'h0);

        // rvalid while idle is ignored
        mem_rvalid = 1'b1;
        step();
        mem_rvalid = 1'b0;
        check_idle_zero("idle_rvalid");

        // address wrap and no-grant behaviour
        start_walk(32'hFFFFFFFC, 20'h00001);
        check("wrap_addr", mem_addr, 32'h00000000);
        check("wrap_req", 32'(mem_req), 32'h1);
`ifdef SEGRE_PTW_TIMEOUT_EN
        for (int i = 1; i < 16; i++) step();
        check("to_nofault_early", 32'(fault), 32'h0);
        step();
        check("to_fault", 32'(fault), 32'h1);
        check("to_code", 32'(fault_code), 32'h2);
        check("to_vaddr", 32'(fault_vaddr), 32'h00001);
        check("to_req", 32'(mem_req), 32'h0);
        check("to_busy", 32'(busy), 32'h0);
        step();
        check("to_pulse_end", 32'(fault), 32'h0);
`else
        for (int i = 0; i < 20; i++) step();
        check("noto_req", 32'(mem_req), 32'h1);
        check("noto_busy", 32'(busy), 32'h1);
        check("noto_fault", 32'(fault), 32'h0);
        flush = 1'b1;
        step();
        flush = 1'b0;
        check("noto_flush_busy", 32'(busy), 32'h0);
        check("noto_flush_req", 32'(mem_req), 32'h0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

`default_nettype wire
